// File: rtl/multi_winner_selector.sv
// End-of-game result unit: snapshots N scores on game_over, scans one per clock
// for high score / winner / tie set. Optional per-player win counters via WIN_TALLY_EN.
`ifdef WIN_TALLY_EN
module win_counter (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   output logic [7:0] count
);
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                       count <= '0;
      else if (inc && count != 8'hFF)  count <= count + 8'd1;
   end
endmodule
`endif

module multi_winner_selector #(
   parameter  int NUM_PLAYERS = 4,
   parameter  int SCORE_W     = 14,
   localparam int IDW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           game_over,
   input  logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic                           busy,
   output logic                           result_valid,
   output logic [IDW-1:0]                 winner_id,
   output logic                           tie,
   output logic [NUM_PLAYERS-1:0]         tie_mask,
   output logic [SCORE_W-1:0]             high_score,
   output logic [NUM_PLAYERS*SCORE_W-1:0] final_scores,
   output logic [NUM_PLAYERS*8-1:0]       win_tally
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                                state;
   logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   snap;
   logic [IDW-1:0]                        idx, id, id_n;
   logic [SCORE_W-1:0]                    best, best_n, cur;
   logic [NUM_PLAYERS-1:0]                mask, mask_n;
   logic                                  last, finish, tie_n;

   assign final_scores = snap;

   // Next scan accumulator for the snapshot entry at idx.
   always_comb begin
      cur    = snap[idx];
      best_n = best;
      mask_n = mask;
      id_n   = id;
      if (idx == '0) begin
         best_n    = cur;
         mask_n    = '0;
         mask_n[0] = 1'b1;
         id_n      = '0;
      end else if (cur > best) begin
         best_n      = cur;
         mask_n      = '0;
         mask_n[idx] = 1'b1;
         id_n        = idx;
      end else if (cur == best) begin
         mask_n[idx] = 1'b1;
      end
   end

   assign tie_n  = |(mask_n & (mask_n - 1'b1));
   assign last   = (idx == IDW'(NUM_PLAYERS - 1));
   assign finish = (state == SCAN) && game_over && last;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         snap         <= '0;
         idx          <= '0;
         id           <= '0;
         best         <= '0;
         mask         <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         winner_id    <= '0;
         tie          <= 1'b0;
         tie_mask     <= '0;
         high_score   <= '0;
      end else begin
         case (state)
            IDLE: if (game_over) begin
               snap  <= scores;
               idx   <= '0;
               busy  <= 1'b1;
               state <= SCAN;
            end
            SCAN: begin
               // game_over dropping mid-scan aborts with nothing published
               if (!game_over) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  best <= best_n;
                  mask <= mask_n;
                  id   <= id_n;
                  if (finish) begin
                     winner_id    <= id_n;
                     tie_mask     <= mask_n;
                     high_score   <= best_n;
                     tie          <= tie_n;
                     result_valid <= 1'b1;
                     busy         <= 1'b0;
                     state        <= DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DONE: if (!game_over) begin
               result_valid <= 1'b0;
               winner_id    <= '0;
               tie          <= 1'b0;
               tie_mask     <= '0;
               high_score   <= '0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WIN_TALLY_EN
   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_tally
      win_counter u_cnt (
         .clock (clock),
         .reset (reset),
         .inc   (finish && !tie_n && (id_n == IDW'(i))),
         .count (win_tally[i*8 +: 8])
      );
   end
`else
   assign win_tally = '0;
`endif
endmodule

// File: doc/multi_winner_selector.md
# multi_winner_selector

Parametrised end-of-game result unit for N-player matches. On the rising edge of `game_over` it snapshots every player's score, then scans them sequentially, one per clock, to find the high score, the winning player and any tie set. Results are held for the VGA/result display until the game restarts. It sits between the game controller and the display path, replacing the fixed two-player selector.

## Interface
- `NUM_PLAYERS`, default 4: number of players, legal range 2..8.
- `SCORE_W`, default 14: score width in bits; 14 covers 0..9999.
- `IDW`, derived as max(1, $clog2(NUM_PLAYERS)): width of the player index. Not user-set.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `game_over`  in  1  level from the game controller; high while the game is over.
- `scores`  in  NUM_PLAYERS*SCORE_W  live scores, packed; player i occupies `[i*SCORE_W +: SCORE_W]`.
- `busy`  out  1  high while the block is scanning.
- `result_valid`  out  1  high while a finished result is held.
- `winner_id`  out  IDW  lowest-index player holding the high score.
- `tie`  out  1  more than one player holds the high score.
- `tie_mask`  out  NUM_PLAYERS  bit i set when player i holds the high score.
- `high_score`  out  SCORE_W  maximum score.
- `final_scores`  out  NUM_PLAYERS*SCORE_W  latched snapshot, same packing as `scores`.
- `win_tally`  out  NUM_PLAYERS*8  per-player win counts; all zeros unless `WIN_TALLY_EN` is defined.

## Operation
- FSM states: IDLE, SCAN, DONE.
- Reset state is IDLE. Every output resets to 0.
- **IDLE:**
  - When `game_over` is sampled high, capture `scores` into `final_scores`.
  - Clear the scan index to 0 and enter SCAN.
  - `final_scores` keeps its old value until this capture.
- **SCAN:** processes snapshot entry idx each cycle. `busy` is 1.
  - idx=0: set best=s0, mask=onehot(0), id=0.
  - idx>0, s>best: set best=s, mask=onehot(idx), id=idx.
  - idx>0, s==best: set mask |= onehot(idx).
  - idx>0, s<best: no change.
  - Comparison is unsigned, full SCORE_W bits. Scores are never truncated.
  - After idx = NUM_PLAYERS-1, load `winner_id`, `tie_mask`, `high_score` and `tie` (= popcount(mask) > 1), all in the same edge. Then enter DONE.
- **DONE:**
  - `result_valid` is 1. All result outputs are held stable.
  - Changes on `scores` are ignored.
  - When `game_over` is sampled low, return to IDLE. In the same edge clear `result_valid`, `winner_id`, `tie`, `tie_mask` and `high_score`.
  - `final_scores` is kept until the next capture.
- **Abort:** `game_over` sampled low during SCAN returns to IDLE.
  - No result is published; outputs stay 0.
  - `busy` drops on that edge.
- **Re-arm:** a new game needs `game_over` low for at least one cycle. A level held high never triggers a second scan.
- **All-equal scores,** including all zero: `tie`=1, `tie_mask` all ones, `winner_id`=0.
- `reset` asserted in any state forces IDLE and zeroes all outputs immediately. `win_tally` is cleared too.

## Timing
- Edge E0 is the first edge at which `game_over` is sampled high in IDLE.
  - Capture happens at E0.
  - `busy` is high from E0 to E0+NUM_PLAYERS.
  - `result_valid` rises at edge E0+NUM_PLAYERS.
  - Total latency is NUM_PLAYERS+1 cycles; 5 cycles for N=4.
- `result_valid` falls one edge after `game_over` is sampled low.
- All outputs are registered. No combinational path from inputs to outputs.
- Throughput: one result per game_over pulse. The minimum pulse that produces a result is NUM_PLAYERS+1 cycles high.

## Configuration
- `WIN_TALLY_EN` defined:
  - Instantiates one 8-bit saturating counter per player.
  - On the DONE-entry edge, if `tie`=0, increment `win_tally[winner_id]`, holding at 255.
  - Ties and aborts do not count.
  - Counters clear only on `reset`, not on game restart.
- `WIN_TALLY_EN` undefined: no counters; `win_tally` is tied to 0. The port list is identical in both builds.

## Test plan
- N=4, scores {100, 250, 9999, 7}, `game_over` rises:
  - `busy` high for cycles 1..4.
  - `result_valid` high at cycle 5.
  - `winner_id`=2, `high_score`=9999, `tie`=0, `tie_mask`=4'b0100.
- Scores {500, 800, 800, 10}: `winner_id`=1, `tie`=1, `tie_mask`=4'b0110, `high_score`=800.
- Scan abort and restart:
  - `game_over` high 2 cycles then low: no `result_valid`; outputs stay 0.
  - Then a full pulse with all scores zero: `tie_mask`=4'b1111, `winner_id`=0.
- Snapshot hold:
  - Change `scores` during SCAN and DONE: results reflect the E0 snapshot only.
  - Holding `game_over` high for 20 cycles produces no second scan.
  - Dropping `game_over` clears `result_valid` the next edge.
- `reset` asserted mid-SCAN and mid-DONE: all outputs 0 asynchronously; state returns to IDLE.
- With `WIN_TALLY_EN`:
  - 3 rounds won by player 3, then 1 tie round: `win_tally` player 3 = 3, others 0.
  - 260 wins for player 0 saturate at 255.
